// File: rtl/dpram_tdp_be_clr.sv
// dpram_tdp_be_clr: true-dual-port byte-enable RAM with INIT_VALUE clear sequencer; collision_o exists only with DPRAM_COLLISION_FLAG_EN
module dpram_tdp_be_clr #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 10,
    parameter int BE_WIDTH = 4,
    parameter int OUT_REG = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clock0,
    input  logic                  reset,
    input  logic                  clear_i,
    output logic                  ready_o,
    input  logic                  REN1_i,
    input  logic [ADDR_WIDTH-1:0] RD1_ADDR_i,
    output logic [DATA_WIDTH-1:0] RDATA1_o,
    output logic                  RVALID1_o,
    input  logic                  WEN1_i,
    input  logic [ADDR_WIDTH-1:0] WR1_ADDR_i,
    input  logic [DATA_WIDTH-1:0] WDATA1_i,
    input  logic [BE_WIDTH-1:0]   BE1_i,
    input  logic                  REN2_i,
    input  logic [ADDR_WIDTH-1:0] RD2_ADDR_i,
    output logic [DATA_WIDTH-1:0] RDATA2_o,
    output logic                  RVALID2_o,
    input  logic                  WEN2_i,
    input  logic [ADDR_WIDTH-1:0] WR2_ADDR_i,
    input  logic [DATA_WIDTH-1:0] WDATA2_i,
    input  logic [BE_WIDTH-1:0]   BE2_i
`ifdef DPRAM_COLLISION_FLAG_EN
    ,
    output logic                  collision_o
`endif
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW = DATA_WIDTH / BE_WIDTH;
    typedef enum logic {CLEAR, READY} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd1_q, rd2_q;
    logic rv1_q, rv2_q, re1, re2, we1, we2, rv1, rv2;
    assign ready_o = (state == READY);
    assign re1 = ready_o && REN1_i;
    assign re2 = ready_o && REN2_i;
    assign we1 = ready_o && WEN1_i;
    assign we2 = ready_o && WEN2_i;
    always_comb begin
        state_nx = (state == CLEAR) ? ((cnt == '1) ? READY : CLEAR) : (clear_i ? CLEAR : READY);
        cnt_nx = (state == CLEAR) ? cnt + 1'b1 : '0;
    end
    always_ff @(posedge clock0) begin
        if (reset) begin
            state <= CLEAR;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end
    end
    // port 2 lanes are written first so port 1 overrides any lane both enable
    always_ff @(posedge clock0) begin
        if (state == CLEAR) begin
            mem[cnt] <= INIT_VALUE;
        end else begin
            for (int k = 0; k < BE_WIDTH; k++)
                if (we2 && BE2_i[k]) mem[WR2_ADDR_i][k*LW +: LW] <= WDATA2_i[k*LW +: LW];
            for (int k = 0; k < BE_WIDTH; k++)
                if (we1 && BE1_i[k]) mem[WR1_ADDR_i][k*LW +: LW] <= WDATA1_i[k*LW +: LW];
        end
    end
    always_ff @(posedge clock0) begin
        if (reset) begin
            rd1_q <= '0;
            rd2_q <= '0;
            rv1_q <= 1'b0;
            rv2_q <= 1'b0;
        end else begin
            rv1_q <= re1;
            rv2_q <= re2;
            if (re1) rd1_q <= mem[RD1_ADDR_i];
            if (re2) rd2_q <= mem[RD2_ADDR_i];
        end
    end
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] od1_q, od2_q;
            logic ov1_q, ov2_q;
            always_ff @(posedge clock0) begin
                if (reset) begin
                    od1_q <= '0;
                    od2_q <= '0;
                    ov1_q <= 1'b0;
                    ov2_q <= 1'b0;
                end else begin
                    ov1_q <= rv1_q;
                    ov2_q <= rv2_q;
                    if (rv1_q) od1_q <= rd1_q;
                    if (rv2_q) od2_q <= rd2_q;
                end
            end
            assign RDATA1_o = od1_q;
            assign RDATA2_o = od2_q;
            assign rv1 = ov1_q;
            assign rv2 = ov2_q;
        end else begin : g_noreg
            assign RDATA1_o = rd1_q;
            assign RDATA2_o = rd2_q;
            assign rv1 = rv1_q;
            assign rv2 = rv2_q;
        end
    endgenerate
    // a read accepted just before a clear request must not report valid during the clear
    assign RVALID1_o = rv1 && ready_o;
    assign RVALID2_o = rv2 && ready_o;
`ifdef DPRAM_COLLISION_FLAG_EN
    logic coll_q;
    always_ff @(posedge clock0) begin
        if (reset) coll_q <= 1'b0;
        else coll_q <= (we1 && we2 && WR1_ADDR_i == WR2_ADDR_i) ||
                       (we1 && re2 && WR1_ADDR_i == RD2_ADDR_i) ||
                       (we2 && re1 && WR2_ADDR_i == RD1_ADDR_i);
    end
    assign collision_o = coll_q && ready_o;
`endif
endmodule

// File: tb/tb_dpram_tdp_be_clr.sv
// tb_dpram_tdp_be_clr: directed bench for dpram_tdp_be_clr at 36x16, 4 lanes, INIT_VALUE 0
module tb_dpram_tdp_be_clr;
    localparam int OUT_REG = 0;
    logic clock0 = 1'b0;
    logic reset, clear_i, ready_o;
    logic REN1_i, REN2_i, WEN1_i, WEN2_i, RVALID1_o, RVALID2_o;
    logic [3:0] RD1_ADDR_i, RD2_ADDR_i, WR1_ADDR_i, WR2_ADDR_i, BE1_i, BE2_i;
    logic [35:0] RDATA1_o, RDATA2_o, WDATA1_i, WDATA2_i;
`ifdef DPRAM_COLLISION_FLAG_EN
    logic collision_o;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clock0 = ~clock0;

    dpram_tdp_be_clr #(.DATA_WIDTH(36), .ADDR_WIDTH(4), .BE_WIDTH(4), .OUT_REG(OUT_REG), .INIT_VALUE(36'h0)) dut (
        .clock0(clock0), .reset(reset), .clear_i(clear_i), .ready_o(ready_o),
        .REN1_i(REN1_i), .RD1_ADDR_i(RD1_ADDR_i), .RDATA1_o(RDATA1_o), .RVALID1_o(RVALID1_o),
        .WEN1_i(WEN1_i), .WR1_ADDR_i(WR1_ADDR_i), .WDATA1_i(WDATA1_i), .BE1_i(BE1_i),
        .REN2_i(REN2_i), .RD2_ADDR_i(RD2_ADDR_i), .RDATA2_o(RDATA2_o), .RVALID2_o(RVALID2_o),
        .WEN2_i(WEN2_i), .WR2_ADDR_i(WR2_ADDR_i), .WDATA2_i(WDATA2_i), .BE2_i(BE2_i)
`ifdef DPRAM_COLLISION_FLAG_EN
        , .collision_o(collision_o)
`endif
    );

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int p, input logic [3:0] a, input logic [35:0] exp, input string tag);
        if (p == 1) begin REN1_i = 1'b1; RD1_ADDR_i = a; end
        else begin REN2_i = 1'b1; RD2_ADDR_i = a; end
        tick();
        REN1_i = 1'b0;
        REN2_i = 1'b0;
        repeat (OUT_REG) tick();
        chk({tag, "_valid"}, p == 1 ? RVALID1_o : RVALID2_o, 1);
        chk(tag, p == 1 ? RDATA1_o : RDATA2_o, {28'h0, exp});
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [35:0] d, input logic [3:0] be);
        if (p == 1) begin WEN1_i = 1'b1; WR1_ADDR_i = a; WDATA1_i = d; BE1_i = be; end
        else begin WEN2_i = 1'b1; WR2_ADDR_i = a; WDATA2_i = d; BE2_i = be; end
        tick();
        WEN1_i = 1'b0;
        WEN2_i = 1'b0;
    endtask

    task automatic expect_clear(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_busy"}, ready_o, 0);
            tick();
        end
        chk({tag, "_ready"}, ready_o, 1);
    endtask

    initial begin
        reset = 1'b1; clear_i = 1'b0;
        REN1_i = 0; REN2_i = 0; WEN1_i = 0; WEN2_i = 0;
        RD1_ADDR_i = 0; RD2_ADDR_i = 0; WR1_ADDR_i = 0; WR2_ADDR_i = 0;
        WDATA1_i = 0; WDATA2_i = 0; BE1_i = 0; BE2_i = 0;
        repeat (3) tick();
        chk("rst_ready", ready_o, 0);
        chk("rst_rvalid1", RVALID1_o, 0);
        chk("rst_rvalid2", RVALID2_o, 0);
        chk("rst_rdata1", RDATA1_o, 0);
        chk("rst_rdata2", RDATA2_o, 0);
`ifdef DPRAM_COLLISION_FLAG_EN
        chk("rst_coll", collision_o, 0);
`endif
        reset = 1'b0;
        expect_clear("init");
        for (int i = 0; i < 16; i++) begin
            REN1_i = 1; RD1_ADDR_i = 4'(i); REN2_i = 1; RD2_ADDR_i = 4'(15 - i);
            tick();
            REN1_i = 0; REN2_i = 0;
            repeat (OUT_REG) tick();
            chk("init_rd1", RDATA1_o, 0);
            chk("init_rd2", RDATA2_o, 0);
            chk("init_rv1", RVALID1_o, 1);
        end
        wr(1, 3, 36'h123456789, 4'hF);
        rd(2, 3, 36'h123456789, "wr_rd_a3");
        tick();
        chk("hold_rv2", RVALID2_o, 0);
        chk("hold_rd2", RDATA2_o, 36'h123456789);
        wr(1, 5, 36'hFFFFFFFFF, 4'hF);
        wr(2, 5, 36'h0, 4'b0101);
        rd(1, 5, 36'hFF803FE00, "be_a5");
        WEN1_i = 1; WR1_ADDR_i = 7; WDATA1_i = 36'hAAAAAAAAA; BE1_i = 4'hF;
        WEN2_i = 1; WR2_ADDR_i = 7; WDATA2_i = 36'h555555555; BE2_i = 4'hF;
        tick();
        WEN1_i = 0; WEN2_i = 0;
`ifdef DPRAM_COLLISION_FLAG_EN
        chk("coll_ww", collision_o, 1);
`endif
        rd(2, 7, 36'hAAAAAAAAA, "ww_a7");
`ifdef DPRAM_COLLISION_FLAG_EN
        chk("coll_off", collision_o, 0);
`endif
        WEN1_i = 1; WR1_ADDR_i = 9; WDATA1_i = 36'hFFFFFFFFF; BE1_i = 4'b0011;
        WEN2_i = 1; WR2_ADDR_i = 9; WDATA2_i = 36'h0; BE2_i = 4'b1110;
        tick();
        WEN1_i = 0; WEN2_i = 0;
        rd(1, 9, 36'h00003FFFF, "lane_mix_a9");
        WEN1_i = 1; WR1_ADDR_i = 2; WDATA1_i = 36'h1; BE1_i = 4'hF;
        REN2_i = 1; RD2_ADDR_i = 2;
        tick();
        WEN1_i = 0; REN2_i = 0;
`ifdef DPRAM_COLLISION_FLAG_EN
        chk("coll_wr", collision_o, 1);
`endif
        repeat (OUT_REG) tick();
        chk("rf_x_valid", RVALID2_o, 1);
        chk("rf_x_old", RDATA2_o, 0);
        rd(2, 2, 36'h1, "rf_x_new");
        WEN1_i = 1; WR1_ADDR_i = 3; WDATA1_i = 36'hABCDE0123; BE1_i = 4'hF;
        REN1_i = 1; RD1_ADDR_i = 3;
        tick();
        WEN1_i = 0; REN1_i = 0;
        repeat (OUT_REG) tick();
        chk("rf_same_old", RDATA1_o, 36'h123456789);
        rd(1, 3, 36'hABCDE0123, "rf_same_new");
        clear_i = 1;
        tick();
        clear_i = 0;
        REN1_i = 1; RD1_ADDR_i = 3;
        for (int i = 0; i < 16; i++) begin
            chk("clr_busy", ready_o, 0);
            chk("clr_norv", RVALID1_o, 0);
            clear_i = (i == 5);
            tick();
        end
        clear_i = 0; REN1_i = 0;
        chk("clr_ready", ready_o, 1);
        chk("clr_hold", RDATA1_o, 36'hABCDE0123);
        for (int i = 0; i < 16; i++) rd(i % 2 + 1, 4'(i), 36'h0, "clr_rd");
        clear_i = 1;
        tick();
        clear_i = 0;
        repeat (8) tick();
        chk("clr2_busy", ready_o, 0);
        reset = 1;
        tick();
        reset = 0;
        expect_clear("rst_mid");
        rd(1, 15, 36'h0, "rst_mid_rd");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
